// File: rtl/coeff_token_enc02_if.sv
// coeff_token_enc02_if -- request/codeword bus for the coeff_token encoder.
// Carries the token request handshake and the serial codeword stream.
// The token_err line exists only when CT_ENC02_ERR_EN is defined.
// master: the side that issues tokens and consumes codeword bits.
// slave:  the encoder itself.
interface coeff_token_enc02_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] total_coeff;
  logic [1:0] trailing_ones;
  logic       out_valid;
  logic       out_bit;
  logic       out_last;
  logic       out_ready;
  logic [4:0] code_len;
`ifdef CT_ENC02_ERR_EN
  logic       token_err;
`endif

`ifdef CT_ENC02_ERR_EN
  modport master (
    output in_valid, total_coeff, trailing_ones, out_ready,
    input  in_ready, out_valid, out_bit, out_last, code_len, token_err
  );

  modport slave (
    input  in_valid, total_coeff, trailing_ones, out_ready,
    output in_ready, out_valid, out_bit, out_last, code_len, token_err
  );
`else
  modport master (
    output in_valid, total_coeff, trailing_ones, out_ready,
    input  in_ready, out_valid, out_bit, out_last, code_len
  );

  modport slave (
    input  in_valid, total_coeff, trailing_ones, out_ready,
    output in_ready, out_valid, out_bit, out_last, code_len
  );
`endif
endinterface

// File: rtl/coeff_token_enc02.sv
// coeff_token_enc02 -- H.264 coeff_token VLC encoder, 0 <= nC < 2 table.
// Accepts a (TotalCoeff, TrailingOnes) pair, looks up its codeword and
// streams it out MSB first, one bit per consumed transfer.
// Illegal pairs are consumed without producing a codeword.
// Optional feature macro: CT_ENC02_ERR_EN -- adds a one-cycle token_err
// pulse following the acceptance of an illegal pair.
module coeff_token_enc02 (
  input  logic                 clk,
  input  logic                 rst_n,
  coeff_token_enc02_if.slave   bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]  state;
  logic [15:0] shift_reg;
  logic [4:0]  rem_cnt;
  logic [4:0]  code_len_q;
  logic [15:0] lut_code;
  logic [4:0]  lut_len;
  logic [4:0]  just_amt;
  logic [15:0] just_code;
  logic        pair_legal;
  logic        accept;

  // Legality of the presented pair; TrailingOnes can never exceed 3 by width
  always_comb begin
    pair_legal = (bus.total_coeff <= 5'd16) &&
                 ({3'b000, bus.trailing_ones} <= bus.total_coeff);
  end

  // Codeword table, right-justified value plus length; illegal pairs map to length 0
  always_comb begin
    lut_code = 16'd0;
    lut_len  = 5'd0;
    case ({bus.total_coeff, bus.trailing_ones})
      {5'd0,  2'd0}: begin lut_code = 16'd1;  lut_len = 5'd1;  end
      {5'd1,  2'd0}: begin lut_code = 16'd5;  lut_len = 5'd6;  end
      {5'd1,  2'd1}: begin lut_code = 16'd1;  lut_len = 5'd2;  end
      {5'd2,  2'd0}: begin lut_code = 16'd7;  lut_len = 5'd8;  end
      {5'd2,  2'd1}: begin lut_code = 16'd4;  lut_len = 5'd6;  end
      {5'd2,  2'd2}: begin lut_code = 16'd1;  lut_len = 5'd3;  end
      {5'd3,  2'd0}: begin lut_code = 16'd7;  lut_len = 5'd9;  end
      {5'd3,  2'd1}: begin lut_code = 16'd6;  lut_len = 5'd8;  end
      {5'd3,  2'd2}: begin lut_code = 16'd5;  lut_len = 5'd7;  end
      {5'd3,  2'd3}: begin lut_code = 16'd3;  lut_len = 5'd5;  end
      {5'd4,  2'd0}: begin lut_code = 16'd7;  lut_len = 5'd10; end
      {5'd4,  2'd1}: begin lut_code = 16'd6;  lut_len = 5'd9;  end
      {5'd4,  2'd2}: begin lut_code = 16'd5;  lut_len = 5'd8;  end
      {5'd4,  2'd3}: begin lut_code = 16'd3;  lut_len = 5'd6;  end
      {5'd5,  2'd0}: begin lut_code = 16'd7;  lut_len = 5'd11; end
      {5'd5,  2'd1}: begin lut_code = 16'd6;  lut_len = 5'd10; end
      {5'd5,  2'd2}: begin lut_code = 16'd5;  lut_len = 5'd9;  end
      {5'd5,  2'd3}: begin lut_code = 16'd4;  lut_len = 5'd7;  end
      {5'd6,  2'd0}: begin lut_code = 16'd15; lut_len = 5'd13; end
      {5'd6,  2'd1}: begin lut_code = 16'd6;  lut_len = 5'd11; end
      {5'd6,  2'd2}: begin lut_code = 16'd5;  lut_len = 5'd10; end
      {5'd6,  2'd3}: begin lut_code = 16'd4;  lut_len = 5'd8;  end
      {5'd7,  2'd0}: begin lut_code = 16'd11; lut_len = 5'd13; end
      {5'd7,  2'd1}: begin lut_code = 16'd14; lut_len = 5'd13; end
      {5'd7,  2'd2}: begin lut_code = 16'd5;  lut_len = 5'd11; end
      {5'd7,  2'd3}: begin lut_code = 16'd4;  lut_len = 5'd9;  end
      {5'd8,  2'd0}: begin lut_code = 16'd8;  lut_len = 5'd13; end
      {5'd8,  2'd1}: begin lut_code = 16'd10; lut_len = 5'd13; end
      {5'd8,  2'd2}: begin lut_code = 16'd13; lut_len = 5'd13; end
      {5'd8,  2'd3}: begin lut_code = 16'd4;  lut_len = 5'd10; end
      {5'd9,  2'd0}: begin lut_code = 16'd15; lut_len = 5'd14; end
      {5'd9,  2'd1}: begin lut_code = 16'd14; lut_len = 5'd14; end
      {5'd9,  2'd2}: begin lut_code = 16'd9;  lut_len = 5'd13; end
      {5'd9,  2'd3}: begin lut_code = 16'd4;  lut_len = 5'd11; end
      {5'd10, 2'd0}: begin lut_code = 16'd11; lut_len = 5'd14; end
      {5'd10, 2'd1}: begin lut_code = 16'd10; lut_len = 5'd14; end
      {5'd10, 2'd2}: begin lut_code = 16'd13; lut_len = 5'd14; end
      {5'd10, 2'd3}: begin lut_code = 16'd12; lut_len = 5'd13; end
      {5'd11, 2'd0}: begin lut_code = 16'd15; lut_len = 5'd15; end
      {5'd11, 2'd1}: begin lut_code = 16'd14; lut_len = 5'd15; end
      {5'd11, 2'd2}: begin lut_code = 16'd9;  lut_len = 5'd14; end
      {5'd11, 2'd3}: begin lut_code = 16'd12; lut_len = 5'd14; end
      {5'd12, 2'd0}: begin lut_code = 16'd11; lut_len = 5'd15; end
      {5'd12, 2'd1}: begin lut_code = 16'd10; lut_len = 5'd15; end
      {5'd12, 2'd2}: begin lut_code = 16'd13; lut_len = 5'd15; end
      {5'd12, 2'd3}: begin lut_code = 16'd8;  lut_len = 5'd14; end
      {5'd13, 2'd0}: begin lut_code = 16'd15; lut_len = 5'd16; end
      {5'd13, 2'd1}: begin lut_code = 16'd1;  lut_len = 5'd15; end
      {5'd13, 2'd2}: begin lut_code = 16'd9;  lut_len = 5'd15; end
      {5'd13, 2'd3}: begin lut_code = 16'd12; lut_len = 5'd15; end
      {5'd14, 2'd0}: begin lut_code = 16'd11; lut_len = 5'd16; end
      {5'd14, 2'd1}: begin lut_code = 16'd14; lut_len = 5'd16; end
      {5'd14, 2'd2}: begin lut_code = 16'd13; lut_len = 5'd16; end
      {5'd14, 2'd3}: begin lut_code = 16'd8;  lut_len = 5'd15; end
      {5'd15, 2'd0}: begin lut_code = 16'd7;  lut_len = 5'd16; end
      {5'd15, 2'd1}: begin lut_code = 16'd10; lut_len = 5'd16; end
      {5'd15, 2'd2}: begin lut_code = 16'd9;  lut_len = 5'd16; end
      {5'd15, 2'd3}: begin lut_code = 16'd12; lut_len = 5'd16; end
      {5'd16, 2'd0}: begin lut_code = 16'd4;  lut_len = 5'd16; end
      {5'd16, 2'd1}: begin lut_code = 16'd6;  lut_len = 5'd16; end
      {5'd16, 2'd2}: begin lut_code = 16'd5;  lut_len = 5'd16; end
      {5'd16, 2'd3}: begin lut_code = 16'd8;  lut_len = 5'd16; end
      default:       begin lut_code = 16'd0;  lut_len = 5'd0;  end
    endcase
  end

  // Left-justify the codeword so the first bit to send sits in bit 15
  always_comb begin
    just_amt  = 5'd16 - lut_len;
    just_code = lut_code << just_amt;
  end

  // A request is consumed whenever the block is idle, legal or not
  always_comb begin
    accept = (state == IDLE) && bus.in_valid;
  end

  // Two-state sequencer: load a legal codeword on accept, shift it out on each transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= 16'd0;
      rem_cnt    <= 5'd0;
      code_len_q <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && pair_legal) begin
            shift_reg  <= just_code;
            rem_cnt    <= lut_len;
            code_len_q <= lut_len;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.out_ready) begin
            shift_reg <= {shift_reg[14:0], 1'b0};
            rem_cnt   <= rem_cnt - 5'd1;
            if (rem_cnt == 5'd1) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CT_ENC02_ERR_EN
  logic token_err_q;

  // One-cycle flag raised after an illegal pair has been consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      token_err_q <= 1'b0;
    end else begin
      token_err_q <= accept && !pair_legal;
    end
  end

  assign bus.token_err = token_err_q;
`endif

  // Output decode straight from state and the shift register MSB
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == SHIFT);
    bus.out_bit   = (state == SHIFT) && shift_reg[15];
    bus.out_last  = (state == SHIFT) && (rem_cnt == 5'd1);
    bus.code_len  = code_len_q;
  end

endmodule

// File: tb/tb_coeff_token_enc02.sv
// tb_coeff_token_enc02 -- directed bench for the coeff_token encoder.
// Expected codewords are hand-copied bit strings from the nC 0..2 table.
module tb_coeff_token_enc02;

  logic clk;
  logic rst_n;
  int   assert_count;
  int   fail_count;

  coeff_token_enc02_if bus_if ();

  coeff_token_enc02 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", tag, observed, expected, $time);
    end
  endtask

  // Present one request for a single cycle, leaving the bench at the negedge after accept
  task automatic applyStimulus(input logic [4:0] tc, input logic [1:0] t1);
    @(negedge clk);
    checkOutput($sformatf("in_ready_pre_%0d_%0d", tc, t1), bus_if.in_ready, 1);
    bus_if.in_valid      = 1'b1;
    bus_if.total_coeff   = tc;
    bus_if.trailing_ones = t1;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
  endtask

  // Walk a codeword at full out_ready, checking every bit, last flag and length
  task automatic expectCode(input string name, input string pattern);
    byte c;
    int  n;
    n = pattern.len();
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      c = pattern.getc(i);
      checkOutput($sformatf("%s_valid%0d", name, i), bus_if.out_valid, 1);
      checkOutput($sformatf("%s_bit%0d", name, i), bus_if.out_bit, (c == 8'h31) ? 1 : 0);
      checkOutput($sformatf("%s_last%0d", name, i), bus_if.out_last, (i == n - 1) ? 1 : 0);
      checkOutput($sformatf("%s_ready%0d", name, i), bus_if.in_ready, 0);
      checkOutput($sformatf("%s_len%0d", name, i), bus_if.code_len, n);
      @(negedge clk);
    end
    checkOutput($sformatf("%s_idle_ready", name), bus_if.in_ready, 1);
    checkOutput($sformatf("%s_idle_valid", name), bus_if.out_valid, 0);
  endtask

  // Illegal pair: consumed, no codeword, optional error pulse
  task automatic expectDrop(input string name, input logic [4:0] tc, input logic [1:0] t1);
    applyStimulus(tc, t1);
    checkOutput($sformatf("%s_ready_a", name), bus_if.in_ready, 1);
    checkOutput($sformatf("%s_valid_a", name), bus_if.out_valid, 0);
`ifdef CT_ENC02_ERR_EN
    checkOutput($sformatf("%s_err_a", name), bus_if.token_err, 1);
`endif
    @(negedge clk);
    checkOutput($sformatf("%s_ready_b", name), bus_if.in_ready, 1);
    checkOutput($sformatf("%s_valid_b", name), bus_if.out_valid, 0);
`ifdef CT_ENC02_ERR_EN
    checkOutput($sformatf("%s_err_b", name), bus_if.token_err, 0);
`endif
  endtask

  // Main directed sequence
  initial begin
    assert_count = 0;
    fail_count   = 0;
    bus_if.in_valid      = 1'b0;
    bus_if.total_coeff   = 5'd0;
    bus_if.trailing_ones = 2'd0;
    bus_if.out_ready     = 1'b1;
    rst_n = 1'b0;
    #12;
    checkOutput("rst_in_ready", bus_if.in_ready, 1);
    checkOutput("rst_out_valid", bus_if.out_valid, 0);
    checkOutput("rst_out_bit", bus_if.out_bit, 0);
    checkOutput("rst_out_last", bus_if.out_last, 0);
    checkOutput("rst_code_len", bus_if.code_len, 0);
`ifdef CT_ENC02_ERR_EN
    checkOutput("rst_token_err", bus_if.token_err, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(5'd0, 2'd0);
    expectCode("tc0t0", "1");
    applyStimulus(5'd2, 2'd2);
    expectCode("tc2t2", "001");
    applyStimulus(5'd3, 2'd3);
    expectCode("tc3t3", "00011");
    applyStimulus(5'd1, 2'd0);
    expectCode("tc1t0", "000101");
    applyStimulus(5'd5, 2'd1);
    expectCode("tc5t1", "0000000110");
    applyStimulus(5'd8, 2'd2);
    expectCode("tc8t2", "0000000001101");
    applyStimulus(5'd13, 2'd1);
    expectCode("tc13t1", "000000000000001");
    applyStimulus(5'd16, 2'd3);
    expectCode("tc16t3", "0000000000001000");

    // Stall: out_ready 1,0,0,1 with in_valid held high through the codeword
    @(negedge clk);
    bus_if.in_valid      = 1'b1;
    bus_if.total_coeff   = 5'd1;
    bus_if.trailing_ones = 2'd1;
    bus_if.out_ready     = 1'b1;
    @(negedge clk);
    checkOutput("stall_b0_valid", bus_if.out_valid, 1);
    checkOutput("stall_b0_bit", bus_if.out_bit, 0);
    checkOutput("stall_b0_last", bus_if.out_last, 0);
    checkOutput("stall_b0_ready", bus_if.in_ready, 0);
    @(negedge clk);
    checkOutput("stall_b1_bit", bus_if.out_bit, 1);
    checkOutput("stall_b1_last", bus_if.out_last, 1);
    bus_if.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_hold%0d_valid", k), bus_if.out_valid, 1);
      checkOutput($sformatf("stall_hold%0d_bit", k), bus_if.out_bit, 1);
      checkOutput($sformatf("stall_hold%0d_last", k), bus_if.out_last, 1);
      checkOutput($sformatf("stall_hold%0d_ready", k), bus_if.in_ready, 0);
    end
    bus_if.out_ready = 1'b1;
    bus_if.in_valid  = 1'b0;
    @(negedge clk);
    checkOutput("stall_done_ready", bus_if.in_ready, 1);
    checkOutput("stall_done_valid", bus_if.out_valid, 0);
    checkOutput("stall_done_len", bus_if.code_len, 2);

    // Asynchronous reset in the middle of the longest codeword
    applyStimulus(5'd16, 2'd3);
    for (int k = 0; k < 5; k++) @(negedge clk);
    checkOutput("mid_valid_pre", bus_if.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", bus_if.out_valid, 0);
    checkOutput("arst_in_ready", bus_if.in_ready, 1);
    checkOutput("arst_out_last", bus_if.out_last, 0);
    checkOutput("arst_code_len", bus_if.code_len, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(5'd0, 2'd0);
    expectCode("post_rst", "1");

    // Illegal pairs are swallowed without a codeword
    expectDrop("ill_tc1t2", 5'd1, 2'd2);
    expectDrop("ill_tc17", 5'd17, 2'd0);

    // A legal token still encodes correctly after the dropped requests
    applyStimulus(5'd4, 2'd3);
    expectCode("tc4t3", "000011");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
